// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares one single-port unified memory between the fetch stage (instruction
// reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
// Data accesses normally win a tie. A saturating starvation counter hands the
// next tie to fetch after STARVE_MAX consecutive fetch losses. Each access is
// carried over a req/ack handshake to the memory. Completion is reported to
// the owner with a one-cycle ready pulse and registered read data.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   i_req, i_addr                   fetch request (held until i_ready)
//   i_rdata, i_ready                fetched word + one-cycle completion pulse
//   d_req, d_we, d_addr, d_wdata    data request (held until d_ready)
//   d_rdata, d_ready                load data + one-cycle completion pulse
//   stall_fetch, stall_mem          combinational stalls for hazard logic
//   mem_req, mem_we, mem_addr,      registered memory request, held stable
//   mem_wdata                       until mem_ack
//   mem_rdata, mem_ack              memory read data + one-cycle ack
module mem_port_arbiter #(
    parameter int WORD       = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [WORD-1:0]   i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WORD-1:0]   d_wdata,
    output logic [WORD-1:0]   d_rdata,
    output logic              d_ready,
    output logic              stall_fetch,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD-1:0]   mem_wdata,
    input  logic [WORD-1:0]   mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        ACC_I,
        ACC_D,
        DONE
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] STARVE_SAT = 4'hF;

    state_t              state;
    state_t              stateNext;
    logic [3:0]          starveCnt;
    logic [3:0]          starveCntNext;
    logic                memReqNext;
    logic                memWeNext;
    logic [ADDR_W-1:0]   memAddrNext;
    logic [WORD-1:0]     memWdataNext;
    logic [WORD-1:0]     iRdataNext;
    logic [WORD-1:0]     dRdataNext;
    logic                iReadyNext;
    logic                dReadyNext;
    logic                grantData;
    logic                grantFetch;

    // Stalls are combinational so the hazard logic sees the release in the
    // same cycle as the ready pulse.
    assign stall_fetch = i_req & ~i_ready;
    assign stall_mem   = d_req & ~d_ready;

    // Tie-break: data wins unless fetch has lost STARVE_MAX ties in a row.
    // Only consulted in IDLE.
    always_comb begin
        grantData  = d_req && !(i_req && (starveCnt >= STARVE_LIM));
        grantFetch = i_req && !grantData;
    end

    always_comb begin
        stateNext     = state;
        starveCntNext = starveCnt;
        memReqNext    = mem_req;
        memWeNext     = mem_we;
        memAddrNext   = mem_addr;
        memWdataNext  = mem_wdata;
        iRdataNext    = i_rdata;
        dRdataNext    = d_rdata;
        iReadyNext    = 1'b0;
        dReadyNext    = 1'b0;

        case (state)
            IDLE: begin
                if (grantData) begin
                    stateNext    = ACC_D;
                    memReqNext   = 1'b1;
                    memWeNext    = d_we;
                    memAddrNext  = d_addr;
                    memWdataNext = d_wdata;
                    // A tie lost by fetch counts toward starvation.
                    if (i_req && (starveCnt != STARVE_SAT)) begin
                        starveCntNext = starveCnt + 4'd1;
                    end
                end else if (grantFetch) begin
                    stateNext     = ACC_I;
                    memReqNext    = 1'b1;
                    memWeNext     = 1'b0;
                    memAddrNext   = i_addr;
                    memWdataNext  = '0;
                    starveCntNext = 4'd0;
                end
            end
            // Requester inputs are ignored here; the latched mem_* values
            // stay stable until the memory acknowledges.
            ACC_I: begin
                if (mem_ack) begin
                    stateNext  = DONE;
                    memReqNext = 1'b0;
                    iRdataNext = mem_rdata;
                    iReadyNext = 1'b1;
                end
            end
            ACC_D: begin
                if (mem_ack) begin
                    stateNext  = DONE;
                    memReqNext = 1'b0;
                    dRdataNext = mem_rdata;
                    dReadyNext = 1'b1;
                end
            end
            // One cycle for the ready pulse; no arbitration, ack ignored.
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Register stage: every output except the stalls leaves from here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            starveCnt <= 4'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveCntNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            i_rdata   <= iRdataNext;
            d_rdata   <= dRdataNext;
            i_ready   <= iReadyNext;
            d_ready   <= dReadyNext;
        end
    end

endmodule
